// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the unified memory port arbiter.
package mem_arb_pkg;

    localparam int ARB_ST_W  = 6;
    localparam int ARB_CNT_W = 32;

    // One-hot state encoding; each state owns a single bit.
    typedef enum logic [ARB_ST_W-1:0] {
        ARB_IDLE      = 6'b000001,
        ARB_I_REQ     = 6'b000010,
        ARB_I_RESP    = 6'b000100,
        ARB_D_RD_REQ  = 6'b001000,
        ARB_D_RD_RESP = 6'b010000,
        ARB_D_WR_REQ  = 6'b100000
    } arb_state_e;

endpackage

// File: rtl/arb_event_cnt.sv
// Wrapping event counter used for per-requester grant statistics.
module arb_event_cnt
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [ARB_CNT_W-1:0] cnt
);

    logic [ARB_CNT_W-1:0] cnt_q;
    logic [ARB_CNT_W-1:0] cnt_d;

    // Next count: add one per enabled cycle, wrapping naturally at 2^32.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + {{(ARB_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the core's fetch and data channels onto one memory port.
// Fixed priority data > fetch, one outstanding transaction at a time.
//
// state         | meaning
// --------------+-------------------------------------------------
// ARB_IDLE      | no grant; arbitrate among pending requests
// ARB_I_REQ     | fetch request presented on the memory port
// ARB_I_RESP    | waiting for / forwarding the fetch response
// ARB_D_RD_REQ  | load request presented on the memory port
// ARB_D_RD_RESP | waiting for / forwarding the load response
// ARB_D_WR_REQ  | store request presented; no response phase
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        Inst_Req_Valid,
    input  logic [31:0] PC,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack,
    output logic [31:0] M_Address,
    output logic        M_MemWrite,
    output logic        M_MemRead,
    output logic [31:0] M_Write_data,
    output logic [3:0]  M_Write_strb,
    input  logic        M_Req_Ack,
    input  logic [31:0] M_Read_data,
    input  logic        M_Read_data_Valid,
    output logic        M_Read_data_Ack,
    output logic [31:0] inst_grant_cnt,
    output logic [31:0] data_grant_cnt
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       inst_cnt_en;
    logic       data_cnt_en;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and output decode. Request strobes and acks are qualified
    // by the granted request still being asserted, so a withdrawn request
    // never produces a handshake on either side.
    always_comb begin
        state_d         = state_q;
        Inst_Req_Ack    = 1'b0;
        Instruction     = '0;
        Inst_Valid      = 1'b0;
        Mem_Req_Ack     = 1'b0;
        Read_data       = '0;
        Read_data_Valid = 1'b0;
        M_Address       = '0;
        M_MemWrite      = 1'b0;
        M_MemRead       = 1'b0;
        M_Write_data    = '0;
        M_Write_strb    = '0;
        M_Read_data_Ack = 1'b0;
        inst_cnt_en     = 1'b0;
        data_cnt_en     = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (MemWrite) begin
                    state_d = ARB_D_WR_REQ;
                end else if (MemRead) begin
                    state_d = ARB_D_RD_REQ;
                end else if (Inst_Req_Valid) begin
                    state_d = ARB_I_REQ;
                end
            end
            ARB_I_REQ: begin
                M_Address    = PC;
                M_MemRead    = Inst_Req_Valid;
                Inst_Req_Ack = Inst_Req_Valid & M_Req_Ack;
                inst_cnt_en  = Inst_Req_Valid & M_Req_Ack;
                if (!Inst_Req_Valid) begin
                    state_d = ARB_IDLE;
                end else if (M_Req_Ack) begin
                    state_d = ARB_I_RESP;
                end
            end
            ARB_I_RESP: begin
                Instruction     = M_Read_data;
                Inst_Valid      = M_Read_data_Valid;
                M_Read_data_Ack = Inst_Ack;
                if (M_Read_data_Valid && Inst_Ack) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_D_RD_REQ: begin
                M_Address   = Address;
                M_MemRead   = MemRead;
                Mem_Req_Ack = MemRead & M_Req_Ack;
                data_cnt_en = MemRead & M_Req_Ack;
                if (!MemRead) begin
                    state_d = ARB_IDLE;
                end else if (M_Req_Ack) begin
                    state_d = ARB_D_RD_RESP;
                end
            end
            ARB_D_RD_RESP: begin
                Read_data       = M_Read_data;
                Read_data_Valid = M_Read_data_Valid;
                M_Read_data_Ack = Read_data_Ack;
                if (M_Read_data_Valid && Read_data_Ack) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_D_WR_REQ: begin
                M_Address    = Address;
                M_MemWrite   = MemWrite;
                M_Write_data = Write_data;
                M_Write_strb = Write_strb;
                Mem_Req_Ack  = MemWrite & M_Req_Ack;
                data_cnt_en  = MemWrite & M_Req_Ack;
                if (!MemWrite || M_Req_Ack) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    arb_event_cnt u_inst_cnt (
        .clk (clk),
        .rst (rst),
        .en  (inst_cnt_en),
        .cnt (inst_grant_cnt)
    );

    arb_event_cnt u_data_cnt (
        .clk (clk),
        .rst (rst),
        .en  (data_cnt_en),
        .cnt (data_grant_cnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change on the falling edge
// and outputs are sampled a little after, away from the rising edge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        Inst_Req_Valid;
    logic [31:0] PC;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;
    logic [31:0] M_Address;
    logic        M_MemWrite;
    logic        M_MemRead;
    logic [31:0] M_Write_data;
    logic [3:0]  M_Write_strb;
    logic        M_Req_Ack;
    logic [31:0] M_Read_data;
    logic        M_Read_data_Valid;
    logic        M_Read_data_Ack;
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;

    int n_checks;
    int n_fails;
    logic [31:0] exp_inst;
    logic [31:0] exp_data;

    mem_port_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .Inst_Req_Valid    (Inst_Req_Valid),
        .PC                (PC),
        .Inst_Req_Ack      (Inst_Req_Ack),
        .Instruction       (Instruction),
        .Inst_Valid        (Inst_Valid),
        .Inst_Ack          (Inst_Ack),
        .Address           (Address),
        .MemWrite          (MemWrite),
        .MemRead           (MemRead),
        .Write_data        (Write_data),
        .Write_strb        (Write_strb),
        .Mem_Req_Ack       (Mem_Req_Ack),
        .Read_data         (Read_data),
        .Read_data_Valid   (Read_data_Valid),
        .Read_data_Ack     (Read_data_Ack),
        .M_Address         (M_Address),
        .M_MemWrite        (M_MemWrite),
        .M_MemRead         (M_MemRead),
        .M_Write_data      (M_Write_data),
        .M_Write_strb      (M_Write_strb),
        .M_Req_Ack         (M_Req_Ack),
        .M_Read_data       (M_Read_data),
        .M_Read_data_Valid (M_Read_data_Valid),
        .M_Read_data_Ack   (M_Read_data_Ack),
        .inst_grant_cnt    (inst_grant_cnt),
        .data_grant_cnt    (data_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        Inst_Req_Valid    = 1'b0;
        PC                = '0;
        Inst_Ack          = 1'b0;
        Address           = '0;
        MemWrite          = 1'b0;
        MemRead           = 1'b0;
        Write_data        = '0;
        Write_strb        = '0;
        Read_data_Ack     = 1'b0;
        M_Req_Ack         = 1'b0;
        M_Read_data       = '0;
        M_Read_data_Valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (dut.state_q !== ARB_IDLE) begin
            n_fails++;
            $display("FAIL reset_state: got %b want %b", dut.state_q, ARB_IDLE);
        end
        n_checks++;
        if (inst_grant_cnt !== 32'd0 || data_grant_cnt !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", inst_grant_cnt, data_grant_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_inst = 32'd0;
        exp_data = 32'd0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        Inst_Req_Valid = 1'b1;
        PC = 32'h0000_0040;
        @(negedge clk);
        #1;
        n_checks++;
        if (M_MemRead !== 1'b1 || M_Address !== 32'h40 || Inst_Req_Ack !== 1'b0) begin
            n_fails++;
            $display("FAIL fetch_req: got rd=%b addr=%h ack=%b want 1/40/0", M_MemRead, M_Address, Inst_Req_Ack);
        end
        @(negedge clk);
        M_Req_Ack = 1'b1;
        #1;
        n_checks++;
        if (Inst_Req_Ack !== 1'b1 || Mem_Req_Ack !== 1'b0) begin
            n_fails++;
            $display("FAIL fetch_ack: got i=%b d=%b want 1/0", Inst_Req_Ack, Mem_Req_Ack);
        end
        exp_inst = exp_inst + 32'd1;
        @(negedge clk);
        M_Req_Ack = 1'b0;
        Inst_Req_Valid = 1'b0;
        M_Read_data = 32'h2402_0005;
        M_Read_data_Valid = 1'b1;
        Inst_Ack = 1'b1;
        #1;
        n_checks++;
        if (Instruction !== 32'h2402_0005 || Inst_Valid !== 1'b1 || M_Read_data_Ack !== 1'b1 || M_MemRead !== 1'b0) begin
            n_fails++;
            $display("FAIL fetch_resp: got data=%h v=%b mack=%b rd=%b want 24020005/1/1/0", Instruction, Inst_Valid, M_Read_data_Ack, M_MemRead);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (dut.state_q !== ARB_IDLE || inst_grant_cnt !== exp_inst) begin
            n_fails++;
            $display("FAIL fetch_done: got st=%b cnt=%h want %b/%h", dut.state_q, inst_grant_cnt, ARB_IDLE, exp_inst);
        end
    endtask

    task automatic test_priority();
        int budget;
        @(negedge clk);
        MemRead = 1'b1;
        Address = 32'h100;
        Inst_Req_Valid = 1'b1;
        PC = 32'h8;
        @(negedge clk);
        M_Req_Ack = 1'b1;
        #1;
        n_checks++;
        if (M_Address !== 32'h100 || M_MemRead !== 1'b1 || Mem_Req_Ack !== 1'b1 || Inst_Req_Ack !== 1'b0) begin
            n_fails++;
            $display("FAIL prio_data_first: got addr=%h rd=%b dack=%b iack=%b want 100/1/1/0", M_Address, M_MemRead, Mem_Req_Ack, Inst_Req_Ack);
        end
        exp_data = exp_data + 32'd1;
        @(negedge clk);
        M_Req_Ack = 1'b0;
        MemRead = 1'b0;
        M_Read_data = 32'hCAFE_0001;
        M_Read_data_Valid = 1'b1;
        Read_data_Ack = 1'b1;
        #1;
        n_checks++;
        if (Read_data !== 32'hCAFE_0001 || Read_data_Valid !== 1'b1 || Inst_Valid !== 1'b0 || M_MemRead !== 1'b0) begin
            n_fails++;
            $display("FAIL prio_read_resp: got data=%h v=%b iv=%b rd=%b want cafe0001/1/0/0", Read_data, Read_data_Valid, Inst_Valid, M_MemRead);
        end
        @(negedge clk);
        M_Read_data_Valid = 1'b0;
        Read_data_Ack = 1'b0;
        #1;
        n_checks++;
        if (dut.state_q !== ARB_IDLE || M_MemRead !== 1'b0) begin
            n_fails++;
            $display("FAIL prio_idle_gap: got st=%b rd=%b want %b/0", dut.state_q, M_MemRead, ARB_IDLE);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (M_Address !== 32'h8 || M_MemRead !== 1'b1) begin
            n_fails++;
            $display("FAIL prio_fetch_next: got addr=%h rd=%b want 8/1", M_Address, M_MemRead);
        end
        M_Req_Ack = 1'b1;
        exp_inst = exp_inst + 32'd1;
        @(negedge clk);
        clear_inputs();
        M_Read_data_Valid = 1'b1;
        M_Read_data = 32'h0000_1234;
        Inst_Ack = 1'b1;
        budget = 0;
        while (dut.state_q !== ARB_IDLE && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        clear_inputs();
        n_checks++;
        if (budget >= 20 || inst_grant_cnt !== exp_inst || data_grant_cnt !== exp_data) begin
            n_fails++;
            $display("FAIL prio_counts: got i=%h d=%h budget=%0d want %h/%h", inst_grant_cnt, data_grant_cnt, budget, exp_inst, exp_data);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        MemWrite = 1'b1;
        MemRead = 1'b1;
        Address = 32'h200;
        Write_data = 32'hDEAD_BEEF;
        Write_strb = 4'h3;
        @(negedge clk);
        #1;
        n_checks++;
        if (M_MemWrite !== 1'b1 || M_MemRead !== 1'b0 || M_Address !== 32'h200 || M_Write_data !== 32'hDEAD_BEEF || M_Write_strb !== 4'h3 || Mem_Req_Ack !== 1'b0) begin
            n_fails++;
            $display("FAIL store_fields: got wr=%b rd=%b a=%h d=%h s=%h ack=%b want 1/0/200/deadbeef/3/0", M_MemWrite, M_MemRead, M_Address, M_Write_data, M_Write_strb, Mem_Req_Ack);
        end
        M_Req_Ack = 1'b1;
        #1;
        n_checks++;
        if (Mem_Req_Ack !== 1'b1) begin
            n_fails++;
            $display("FAIL store_ack: got %b want 1", Mem_Req_Ack);
        end
        exp_data = exp_data + 32'd1;
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (dut.state_q !== ARB_IDLE || data_grant_cnt !== exp_data || M_MemWrite !== 1'b0 || M_Read_data_Ack !== 1'b0) begin
            n_fails++;
            $display("FAIL store_done: got st=%b cnt=%h wr=%b mack=%b want %b/%h/0/0", dut.state_q, data_grant_cnt, M_MemWrite, M_Read_data_Ack, ARB_IDLE, exp_data);
        end
    endtask

    task automatic test_slow_response();
        @(negedge clk);
        MemRead = 1'b1;
        Address = 32'h300;
        M_Req_Ack = 1'b1;
        @(negedge clk);
        exp_data = exp_data + 32'd1;
        @(negedge clk);
        MemRead = 1'b0;
        M_Req_Ack = 1'b0;
        M_Read_data = 32'h0BAD_F00D;
        M_Read_data_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (dut.state_q !== ARB_D_RD_RESP || M_Read_data_Ack !== 1'b0 || Read_data_Valid !== 1'b1) begin
                n_fails++;
                $display("FAIL slow_wait%0d: got st=%b mack=%b v=%b want %b/0/1", i, dut.state_q, M_Read_data_Ack, Read_data_Valid, ARB_D_RD_RESP);
            end
            @(negedge clk);
        end
        Read_data_Ack = 1'b1;
        #1;
        n_checks++;
        if (M_Read_data_Ack !== 1'b1 || Read_data !== 32'h0BAD_F00D) begin
            n_fails++;
            $display("FAIL slow_ack: got mack=%b data=%h want 1/0badf00d", M_Read_data_Ack, Read_data);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (dut.state_q !== ARB_IDLE || data_grant_cnt !== exp_data) begin
            n_fails++;
            $display("FAIL slow_done: got st=%b cnt=%h want %b/%h", dut.state_q, data_grant_cnt, ARB_IDLE, exp_data);
        end
    endtask

    task automatic test_stray_valid();
        @(negedge clk);
        M_Read_data_Valid = 1'b1;
        M_Read_data = 32'h5555_AAAA;
        Inst_Ack = 1'b1;
        Read_data_Ack = 1'b1;
        #1;
        n_checks++;
        if (M_Read_data_Ack !== 1'b0 || Inst_Valid !== 1'b0 || Read_data_Valid !== 1'b0 || Instruction !== 32'd0) begin
            n_fails++;
            $display("FAIL stray_valid: got mack=%b iv=%b dv=%b ins=%h want 0/0/0/0", M_Read_data_Ack, Inst_Valid, Read_data_Valid, Instruction);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_txn();
        @(negedge clk);
        Inst_Req_Valid = 1'b1;
        PC = 32'h44;
        @(negedge clk);
        M_Req_Ack = 1'b1;
        @(negedge clk);
        clear_inputs();
        M_Read_data = 32'h1111_2222;
        M_Read_data_Valid = 1'b1;
        Inst_Ack = 1'b1;
        #1;
        n_checks++;
        if (dut.state_q !== ARB_I_RESP || Inst_Valid !== 1'b1) begin
            n_fails++;
            $display("FAIL rst_pre: got st=%b v=%b want %b/1", dut.state_q, Inst_Valid, ARB_I_RESP);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut.state_q !== ARB_IDLE || Inst_Valid !== 1'b0 || Instruction !== 32'd0 || M_Read_data_Ack !== 1'b0 || M_MemRead !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_async_out: got st=%b v=%b ins=%h mack=%b rd=%b want idle/0/0/0/0", dut.state_q, Inst_Valid, Instruction, M_Read_data_Ack, M_MemRead);
        end
        n_checks++;
        if (inst_grant_cnt !== 32'd0 || data_grant_cnt !== 32'd0) begin
            n_fails++;
            $display("FAIL rst_async_cnt: got %h/%h want 0/0", inst_grant_cnt, data_grant_cnt);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        exp_inst = 32'd0;
        exp_data = 32'd0;
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.u_inst_cnt.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_inst_cnt.cnt_q;
        #1;
        n_checks++;
        if (inst_grant_cnt !== 32'hFFFF_FFFF) begin
            n_fails++;
            $display("FAIL wrap_preload: got %h want ffffffff", inst_grant_cnt);
        end
        @(negedge clk);
        Inst_Req_Valid = 1'b1;
        PC = 32'h4C;
        @(negedge clk);
        M_Req_Ack = 1'b1;
        @(negedge clk);
        clear_inputs();
        M_Read_data_Valid = 1'b1;
        Inst_Ack = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (inst_grant_cnt !== 32'd0 || dut.state_q !== ARB_IDLE) begin
            n_fails++;
            $display("FAIL wrap_result: got cnt=%h st=%b want 0/%b", inst_grant_cnt, dut.state_q, ARB_IDLE);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails = 0;
        test_reset();
        test_single_fetch();
        test_priority();
        test_store();
        test_slow_response();
        test_stray_valid();
        test_reset_mid_txn();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that merges the multi-cycle MIPS core's instruction fetch channel and data memory channel onto one unified memory port. It sits between mips_cpu and the single-ported memory/bus adapter. It uses the same valid/ack request and response handshakes on both sides, with one outstanding transaction at a time. It keeps per-requester grant counters for the performance-counter bank.

## Interface
- No parameters. Address and data are 32 bits; write strobe is 4 bits.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- Inst_Req_Valid  in  1  fetch request from core
- PC  in  32  fetch address, stable while Inst_Req_Valid
- Inst_Req_Ack  out  1  fetch request accepted
- Instruction  out  32  fetch response data
- Inst_Valid  out  1  fetch response valid
- Inst_Ack  in  1  core accepts fetch response
- Address  in  32  data address, word-aligned
- MemWrite  in  1  data write request
- MemRead  in  1  data read request
- Write_data  in  32  store data
- Write_strb  in  4  byte enables
- Mem_Req_Ack  out  1  data request accepted
- Read_data  out  32  load response data
- Read_data_Valid  out  1  load response valid
- Read_data_Ack  in  1  core accepts load response
- M_Address  out  32  memory port address
- M_MemWrite  out  1  memory write request
- M_MemRead  out  1  memory read request
- M_Write_data  out  32  memory write data
- M_Write_strb  out  4  memory byte enables
- M_Req_Ack  in  1  memory accepts request
- M_Read_data  in  32  memory response data
- M_Read_data_Valid  in  1  memory response valid
- M_Read_data_Ack  out  1  arbiter accepts memory response
- inst_grant_cnt  out  32  completed fetch requests
- data_grant_cnt  out  32  completed data requests (reads + writes)

## Operation
- State machine, one-hot, 6 states:
  - IDLE
  - I_REQ, I_RESP
  - D_RD_REQ, D_RD_RESP
  - D_WR_REQ
- IDLE:
  - If MemWrite, go to D_WR_REQ.
  - Else if MemRead, go to D_RD_REQ.
  - Else if Inst_Req_Valid, go to I_REQ.
  - Else stay.
  - Fixed priority: data > instruction. MemWrite together with MemRead is treated as a write.
- Request states:
  - Drive the M_* request from the granted channel. M_MemRead=1 in I_REQ and D_RD_REQ; M_MemWrite=1 in D_WR_REQ.
  - Route M_Req_Ack combinationally to the granted channel's request ack.
  - On M_Req_Ack: I_REQ goes to I_RESP, D_RD_REQ goes to D_RD_RESP, D_WR_REQ goes to IDLE.
  - If the granted request deasserts before ack, return to IDLE without a handshake and without counting.
- Response states:
  - Pass M_Read_data and M_Read_data_Valid to the owner.
  - Drive M_Read_data_Ack from the owner's ack.
  - On a valid&ack handshake, go to IDLE.
- All M_* request outputs are 0 outside request states. M_Read_data_Ack is 0 outside response states.
- Upstream outputs are 0 when their channel is not granted. A stray M_Read_data_Valid in IDLE or request states is not acked.
- Counters increment by 1 on each completed request handshake (M_Req_Ack in a request state) and wrap modulo 2^32.

## Timing
- Reset (asynchronous):
  - state = IDLE
  - both counters = 0
  - every output = 0, since all outputs decode from state
- Arbitration latency: request seen in IDLE at edge N; M_* request asserted during cycle N+1. Minimum fetch cost is IDLE, REQ, RESP = 3 cycles.
- Ack paths (M_Req_Ack → Inst_Req_Ack/Mem_Req_Ack, M_Read_data_Valid → Inst_Valid/Read_data_Valid, and the response acks) are combinational, with no added cycles.
- Back-to-back requests: at least one IDLE cycle between transactions. A losing requester waits in IDLE arbitration and is granted on the next IDLE cycle with no higher-priority request.
- Reset asserted mid-transaction: abort immediately to IDLE. The memory side must also be reset; no response is forwarded after reset.

## Structure
- Package mem_arb_pkg:
  - one-hot state localparams ARB_IDLE…ARB_D_WR_REQ
  - state width constant
  - ARB_CNT_W=32
- One sub-module: arb_event_cnt (32-bit wrapping counter with async reset and enable), instantiated twice.
- FSM and output muxing stay in the top.

## Test plan
- Single fetch: PC=0x00000040, memory acks after 2 cycles and returns 0x24020005 → Instruction=0x24020005 with Inst_Valid; inst_grant_cnt=1; state back to IDLE.
- Simultaneous MemRead (Address=0x100) and Inst_Req_Valid (PC=0x8) in IDLE → data read is served first (M_Address=0x100); fetch (M_Address=0x8) is issued only after the read response handshake.
- Store: MemWrite, Address=0x200, Write_data=0xDEADBEEF, Write_strb=0x3 → M_* fields match; Mem_Req_Ack equals M_Req_Ack; IDLE the next cycle; data_grant_cnt increments; no response state entered.
- Slow response: M_Read_data_Valid held while Read_data_Ack is 0 for 3 cycles → arbiter stays in D_RD_RESP and M_Read_data_Ack=0 until the core acks.
- Reset asserted in I_RESP → all outputs go to 0 asynchronously; state = IDLE; counters = 0.
- Counter wrap: preload the counter at 0xFFFFFFFF (force), complete one fetch → inst_grant_cnt reads 0.
